vram_port_arbiter: RTL and testbench



---
 rtl/ppu_pkg.sv | 35 +++
 rtl/vram_req_fifo.sv | 67 ++++++
 rtl/vram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_vram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared VRAM-side types for the PPU: bus widths, grant/tag encoding, CPU request payload.
package ppu_pkg;

    localparam int unsigned VRAM_AW = 14;
    localparam int unsigned VRAM_DW = 8;

    // Grant of the current cycle; also reused as the one-cycle read-return tag.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PPU  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_e;

    // One buffered CPU-side access.
    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] wdata;
    } cpu_req_t;

    localparam int unsigned CPU_REQ_W = $bits(cpu_req_t);

    // Tag to remember for a grant: only reads come back with data.
    function automatic gnt_e read_tag(input gnt_e gnt, input logic we);
        gnt_e tag;
        tag = GNT_NONE;
        if (gnt == GNT_PPU) begin
            tag = GNT_PPU;
        end else if ((gnt == GNT_CPU) && !we) begin
            tag = GNT_CPU;
        end
        return tag;
    endfunction

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible without a pop.
// A push is ignored while full, even if a pop happens in the same cycle.
module vram_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Qualified push/pop and status flags, all from registered state.
    always_comb begin
        o_full    = (r_count == CNT_W'(DEPTH));
        o_empty   = (r_count == '0);
        w_do_push = i_push && !o_full;
        w_do_pop  = i_pop && !o_empty;
        o_rdata   = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port VRAM between the PPU fetch engine (absolute priority)
// and buffered CPU register-port accesses drained into idle PPU cycles.
module vram_port_arbiter
    import ppu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 341
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ppu_req,
    input  logic [VRAM_AW-1:0]            ppu_addr,
    output logic [VRAM_DW-1:0]            ppu_rdata,
    output logic                          ppu_rvalid,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [VRAM_AW-1:0]            cpu_addr,
    input  logic [VRAM_DW-1:0]            cpu_wdata,
    output logic                          cpu_ready,
    output logic [VRAM_DW-1:0]            cpu_rdata,
    output logic                          cpu_rvalid,
    output logic [VRAM_AW-1:0]            vram_addr,
    output logic [VRAM_DW-1:0]            vram_wdata,
    output logic                          vram_we,
    input  logic [VRAM_DW-1:0]            vram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cpu_starved
);

    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    cpu_req_t           w_push_req;
    cpu_req_t           w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    gnt_e               w_grant;
    logic [STV_W-1:0]   w_starve_next;

    gnt_e               r_tag;
    logic [VRAM_AW-1:0] r_last_addr;
    logic [VRAM_DW-1:0] r_last_wdata;
    logic [STV_W-1:0]   r_starve_cnt;
    logic               r_starved;

    // CPU request buffer; a request pushed this cycle is only grantable next cycle.
    vram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CPU_REQ_W)
    ) u_req_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_push_req),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Grant selection and VRAM drive: PPU first, then FIFO head, else hold address.
    always_comb begin
        w_grant    = GNT_NONE;
        vram_addr  = r_last_addr;
        vram_wdata = r_last_wdata;
        vram_we    = 1'b0;
        if (!reset) begin
            if (ppu_req) begin
                w_grant = GNT_PPU;
            end else if (!w_empty) begin
                w_grant = GNT_CPU;
            end
        end else begin
            vram_addr  = '0;
            vram_wdata = '0;
        end
        case (w_grant)
            GNT_PPU: begin
                vram_addr = ppu_addr;
            end
            GNT_CPU: begin
                vram_addr  = w_head.addr;
                vram_wdata = w_head.wdata;
                vram_we    = w_head.we;
            end
            default: ;
        endcase
    end

    // FIFO handshake: readiness comes from the registered occupancy only.
    always_comb begin
        cpu_ready        = !w_full;
        w_push           = cpu_req && cpu_ready;
        w_pop            = (w_grant == GNT_CPU);
        w_push_req.we    = cpu_we;
        w_push_req.addr  = cpu_addr;
        w_push_req.wdata = cpu_wdata;
    end

    // Starvation counter: counts waiting cycles, clears on service or empty, saturates.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_empty || (w_grant == GNT_CPU)) begin
            w_starve_next = '0;
        end else if (r_starve_cnt != STV_W'(STARVE_LIMIT)) begin
            w_starve_next = r_starve_cnt + STV_W'(1);
        end
    end

    // Read-return pass-through; suppressed while reset is held so a pre-reset read is dropped.
    always_comb begin
        ppu_rvalid  = (r_tag == GNT_PPU) && !reset;
        cpu_rvalid  = (r_tag == GNT_CPU) && !reset;
        ppu_rdata   = ppu_rvalid ? vram_rdata : '0;
        cpu_rdata   = cpu_rvalid ? vram_rdata : '0;
        cpu_starved = r_starved;
    end

    // Registered state: read tag, held VRAM bus values and the sticky starvation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag        <= GNT_NONE;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            r_starve_cnt <= '0;
            r_starved    <= 1'b0;
        end else begin
            r_tag        <= read_tag(w_grant, w_head.we);
            r_last_addr  <= vram_addr;
            r_last_wdata <= vram_wdata;
            r_starve_cnt <= w_starve_next;
            if (w_starve_next == STV_W'(STARVE_LIMIT)) begin
                r_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural VRAM model.
module tb_vram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ppu_req = 1'b0;
    logic [13:0] ppu_addr = '0;
    logic [7:0]  ppu_rdata;
    logic        ppu_rvalid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata = '0;
    logic [2:0]  fifo_count;
    logic        cpu_starved;

    int checks = 0;
    int failures = 0;

    // rdata_mode=1: VRAM returns (addr+1); rdata_mode=0: real memory contents.
    logic        rdata_mode = 1'b1;
    logic [7:0]  vmem [16384];

    vram_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(341)) dut (
        .clock       (clock),
        .reset       (reset),
        .ppu_req     (ppu_req),
        .ppu_addr    (ppu_addr),
        .ppu_rdata   (ppu_rdata),
        .ppu_rvalid  (ppu_rvalid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_rdata  (vram_rdata),
        .fifo_count  (fifo_count),
        .cpu_starved (cpu_starved)
    );

    always #5 clock = ~clock;

    // Single-port VRAM with one cycle of read latency.
    always @(posedge clock) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        vram_rdata <= rdata_mode ? (vram_addr[7:0] + 8'd1) : vmem[vram_addr];
    end

    typedef struct {
        logic        ppu_req;
        logic [13:0] ppu_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [13:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic [13:0] e_vaddr;
        logic        e_we;
        logic [7:0]  e_wdata;
        logic        e_prv;
        logic [7:0]  e_prdata;
        logic        e_crv;
        logic [7:0]  e_crdata;
        logic [2:0]  e_count;
        logic        e_ready;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pr, input logic [13:0] pa, input logic cr,
                         input logic cw, input logic [13:0] ca, input logic [7:0] cd);
        ppu_req = pr; ppu_addr = pa; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;

        vecs[0]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h2000, 8'h5A, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h2000, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h2000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 14'h0000, 1'b1, 1'b0, 14'h0123, 8'h00, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, 14'h0001, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0001, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[6]  = '{1'b1, 14'h0002, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0002, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[7]  = '{1'b1, 14'h0003, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0003, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[8]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0123, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[9]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h24, 3'd0, 1'b1};
        vecs[10] = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};

        // Reset
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_prv", 32'(ppu_rvalid), 32'd0);
        chk("rst_crv", 32'(cpu_rvalid), 32'd0);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_starved", 32'(cpu_starved), 32'd0);
        chk("rst_vaddr", 32'(vram_addr), 32'd0);
        chk("rst_prdata", 32'(ppu_rdata), 32'd0);
        tick();

        // Table-driven basic sequence
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ppu_req, vecs[i].ppu_addr, vecs[i].cpu_req,
                  vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata);
            @(negedge clock);
            chk($sformatf("v%0d_vaddr", i), 32'(vram_addr), 32'(vecs[i].e_vaddr));
            chk($sformatf("v%0d_we", i), 32'(vram_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), 32'(vram_wdata), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_prv", i), 32'(ppu_rvalid), 32'(vecs[i].e_prv));
            if (vecs[i].e_prv) chk($sformatf("v%0d_prdata", i), 32'(ppu_rdata), 32'(vecs[i].e_prdata));
            chk($sformatf("v%0d_crv", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
            if (vecs[i].e_crv) chk($sformatf("v%0d_crdata", i), 32'(cpu_rdata), 32'(vecs[i].e_crdata));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vecs[i].e_ready));
            tick();
        end

        // Continuous PPU burst 0x0000..0x000F with a CPU write queued behind it
        for (int i = 0; i <= 16; i++) begin
            drive(i < 16, 14'(i), i == 0, 1'b1, 14'h0AAA, 8'h77);
            @(negedge clock);
            if (i < 16) begin
                chk($sformatf("burst%0d_vaddr", i), 32'(vram_addr), 32'(i));
                chk($sformatf("burst%0d_we", i), 32'(vram_we), 32'd0);
            end else begin
                chk("burst_cpu_vaddr", 32'(vram_addr), 32'h0AAA);
                chk("burst_cpu_we", 32'(vram_we), 32'd1);
                chk("burst_cpu_wdata", 32'(vram_wdata), 32'h77);
            end
            chk($sformatf("burst%0d_prv", i), 32'(ppu_rvalid), 32'(i > 0));
            if (i > 0) chk($sformatf("burst%0d_prdata", i), 32'(ppu_rdata), 32'(i));
            if (i > 0) chk($sformatf("burst%0d_count", i), 32'(fifo_count), 32'd1);
            tick();
        end
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        @(negedge clock);
        chk("burst_drained", 32'(fifo_count), 32'd0);
        tick();

        // Fill FIFO while PPU is busy; fifth request refused
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 14'h0100, 1'b1, (k % 2) == 0, 14'(14'h1000 + k), 8'(8'hA0 + k));
            @(negedge clock);
            chk($sformatf("fill%0d_count", k), 32'(fifo_count), 32'(k));
            chk($sformatf("fill%0d_ready", k), 32'(cpu_ready), 32'(k < 4));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
            @(negedge clock);
            chk($sformatf("drain%0d_vaddr", k), 32'(vram_addr), 32'(14'h1000 + k));
            chk($sformatf("drain%0d_we", k), 32'(vram_we), 32'((k % 2) == 0));
            if ((k % 2) == 0) chk($sformatf("drain%0d_wdata", k), 32'(vram_wdata), 32'(8'hA0 + k));
            chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(4 - k));
            chk($sformatf("drain%0d_crv", k), 32'(cpu_rvalid), 32'(k == 2));
            tick();
        end
        @(negedge clock);
        chk("drain_end_count", 32'(fifo_count), 32'd0);
        chk("drain_end_vaddr", 32'(vram_addr), 32'h1003);
        chk("drain_end_crv", 32'(cpu_rvalid), 32'd1);
        chk("drain_end_we", 32'(vram_we), 32'd0);
        tick();

        // Write then read the same address through real memory
        rdata_mode = 1'b0;
        drive(1'b0, 14'h0, 1'b1, 1'b1, 14'h3F00, 8'h0F);
        @(negedge clock);
        chk("wr_crv_a", 32'(cpu_rvalid), 32'd0);
        tick();
        drive(1'b0, 14'h0, 1'b1, 1'b0, 14'h3F00, 8'h00);
        @(negedge clock);
        chk("wr_grant_we", 32'(vram_we), 32'd1);
        chk("wr_crv_b", 32'(cpu_rvalid), 32'd0);
        tick();
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        @(negedge clock);
        chk("rd_grant_vaddr", 32'(vram_addr), 32'h3F00);
        chk("rd_grant_we", 32'(vram_we), 32'd0);
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        @(negedge clock);
        chk("rd_crv", 32'(cpu_rvalid), 32'd1);
        chk("rd_crdata", 32'(cpu_rdata), 32'h0F);
        tick();
        @(negedge clock);
        chk("rd_crv_once", 32'(cpu_rvalid), 32'd0);
        tick();
        rdata_mode = 1'b1;

        // Starvation: PPU holds the port while one CPU request waits
        drive(1'b1, 14'h0000, 1'b1, 1'b1, 14'h0200, 8'h11);
        tick();
        drive(1'b1, 14'h0000, 1'b0, 1'b0, 14'h0, 8'h0);
        for (int n = 1; n <= 341; n++) begin
            @(negedge clock);
            if (n == 1 || n == 340 || n == 341)
                chk($sformatf("starve_cyc%0d", n), 32'(cpu_starved), 32'd0);
            tick();
        end
        @(negedge clock);
        chk("starve_set", 32'(cpu_starved), 32'd1);
        chk("starve_count", 32'(fifo_count), 32'd1);
        tick();
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        @(negedge clock);
        chk("starve_grant_vaddr", 32'(vram_addr), 32'h0200);
        tick();
        @(negedge clock);
        chk("starve_sticky", 32'(cpu_starved), 32'd1);
        chk("starve_drained", 32'(fifo_count), 32'd0);
        tick();

        // Reset right after a CPU read grant
        drive(1'b0, 14'h0, 1'b1, 1'b0, 14'h0055, 8'h00);
        tick();
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        @(negedge clock);
        chk("pre_rst_vaddr", 32'(vram_addr), 32'h0055);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("in_rst_crv", 32'(cpu_rvalid), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_crv", 32'(cpu_rvalid), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_starved", 32'(cpu_starved), 32'd0);
        chk("post_rst_ready", 32'(cpu_ready), 32'd1);
        chk("post_rst_vaddr", 32'(vram_addr), 32'd0);
        tick();
        @(negedge clock);
        chk("post_rst_crv2", 32'(cpu_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
